// File: rtl/cdma_wt_arb_pkg.sv
// Shared constants, types and helpers for the CDMA weight-request arbiter.
package cdma_wt_arb_pkg;

  localparam int unsigned TAG_W   = 5;
  localparam int unsigned DEPTH   = 128;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_W1  = CNT_W + 1;
  localparam int unsigned ENT_W   = TAG_W + 1;
  localparam int unsigned SRC_BIT = TAG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic             src;
    logic [TAG_W-1:0] tag;
  } wr_ent_t;

  // Zero or anything above DEPTH falls back to the hard ceiling.
  function automatic logic [CNT_W-1:0] eff_limit(input logic [CNT_W-1:0] cfg);
    if (cfg == '0 || cfg > CNT_W'(DEPTH)) return CNT_W'(DEPTH);
    return cfg;
  endfunction

  // Up/down step that holds at zero on a lone decrement.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    if (inc && !dec) return cnt + CNT_W'(1);
    if (dec && !inc && cnt != '0) return cnt - CNT_W'(1);
    return cnt;
  endfunction

endpackage

// File: rtl/cdma_wt_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when a grant is issued.
module cdma_wt_rr_arb2 (
  input  logic       clk,
  input  logic       reset_,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;
  logic ptr_nxt;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) ptr <= 1'b0;
    else         ptr <= ptr_nxt;
  end

  // Contended grants follow ptr; a lone grant hands priority to the other side.
  always_comb begin
    gnt     = 2'b00;
    ptr_nxt = ptr;
    if (en) begin
      unique case (valid)
        2'b11: begin
          gnt[ptr] = 1'b1;
          ptr_nxt  = ~ptr;
        end
        2'b01: begin
          gnt     = 2'b01;
          ptr_nxt = 1'b1;
        end
        2'b10: begin
          gnt     = 2'b10;
          ptr_nxt = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cdma_wt_req_arb.sv
// Merges two tag streams into the weight-request FIFO, tracks occupancy by
// snooping the read port, and sequences start/drain from op_en.
module cdma_wt_req_arb
  import cdma_wt_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset_,
  input  logic             op_en,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             req0_valid,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             fifo_wr_req,
  output logic [ENT_W-1:0] fifo_wr_data,
  input  logic             fifo_wr_ready,
  input  logic             fifo_rd_req,
  input  logic             fifo_rd_ready,
  input  logic [ENT_W-1:0] fifo_rd_data,
  output logic [CNT_W-1:0] outs0_cnt,
  output logic [CNT_W-1:0] outs1_cnt,
  output logic             idle,
  output logic             drain_done,
  output logic             err
);

  state_e           state, state_nxt;
  wr_ent_t          wr_ent;
  logic [CNT_W-1:0] occ_cnt;
  logic [CNT_W-1:0] lim;
  logic [CNT_W1-1:0] inflight;
  logic             acc, pop, rd_src;
  logic             credit_ok, slot_free, grant_en;
  logic             done_nxt, underflow;
  logic [1:0]       gnt;
  logic             unused_rd_tag;

  assign unused_rd_tag = ^fifo_rd_data[TAG_W-1:0];

  assign acc       = fifo_wr_req & fifo_wr_ready;
  assign pop       = fifo_rd_req & fifo_rd_ready;
  assign rd_src    = fifo_rd_data[SRC_BIT];
  assign lim       = eff_limit(cfg_limit);
  // The pending output entry is already committed, so it consumes credit.
  assign inflight  = {1'b0, occ_cnt} + CNT_W1'(fifo_wr_req);
  assign credit_ok = inflight < {1'b0, lim};
  assign slot_free = !fifo_wr_req || acc;
  assign grant_en  = (state == RUN) && slot_free && credit_ok;

  cdma_wt_rr_arb2 u_rr (
    .clk    (clk),
    .reset_ (reset_),
    .valid  ({req1_valid, req0_valid}),
    .en     (grant_en),
    .gnt    (gnt)
  );

  assign req0_ready   = gnt[0];
  assign req1_ready   = gnt[1];
  assign fifo_wr_data = wr_ent;

  assign underflow = (pop && !acc && occ_cnt == '0)
                  || (pop && !rd_src && !(acc && !wr_ent.src) && outs0_cnt == '0)
                  || (pop &&  rd_src && !(acc &&  wr_ent.src) && outs1_cnt == '0);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE:  if (op_en) state_nxt = RUN;
      RUN:   if (!op_en) state_nxt = DRAIN;
      DRAIN: if (occ_cnt == '0 && !fifo_wr_req && !acc) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state      <= IDLE;
      idle       <= 1'b1;
      drain_done <= 1'b0;
      err        <= 1'b0;
      fifo_wr_req <= 1'b0;
      wr_ent     <= '0;
      occ_cnt    <= '0;
      outs0_cnt  <= '0;
      outs1_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      idle       <= (state_nxt == IDLE);
      drain_done <= done_nxt;
      err        <= err | underflow;
      if (|gnt) begin
        fifo_wr_req <= 1'b1;
        wr_ent      <= '{src: gnt[1], tag: (gnt[1] ? req1_tag : req0_tag)};
      end else if (acc) begin
        fifo_wr_req <= 1'b0;
      end
      occ_cnt   <= cnt_step(occ_cnt, acc, pop);
      outs0_cnt <= cnt_step(outs0_cnt, acc && !wr_ent.src, pop && !rd_src);
      outs1_cnt <= cnt_step(outs1_cnt, acc &&  wr_ent.src, pop &&  rd_src);
    end
  end

endmodule
